// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: transmit half of the CPU UART.
// Takes one byte per DataInValid/DataInReady handshake and sends it on SOut,
// LSB first, at BAUD_RATE: 8N1 by default.
// Build option: define UART_TX_PARITY_EN to add an even parity bit after the
// last data bit (8E1, 11 symbols per frame).
// Reset is synchronous and active-high. SOut and DataInReady come straight
// from flops, so the serial pin sees no glitches.
module uart_tx_serializer #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut
);

    localparam int unsigned SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W         = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
    localparam int unsigned BIT_W         = 3;
    localparam int unsigned DATA_W        = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned SHIFT_W       = DATA_W + 1;
`else
    localparam int unsigned SHIFT_W       = DATA_W;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic                 sout_q, sout_d;
    logic                 ready_q, ready_d;
    logic                 baud_last_c;
    logic                 accept_c;
    logic [SHIFT_W-1:0]   load_c;

    // End of the current symbol period
    assign baud_last_c = (baud_q == CNT_W'(SYMBOL_CYCLES - 1));

    // Handshake completes on this edge
    assign accept_c = DataInValid && ready_q;

    // Frame payload captured on accept; the parity bit rides above the data byte
`ifdef UART_TX_PARITY_EN
    assign load_c = {^DataIn, DataIn};
`else
    assign load_c = DataIn;
`endif

    // State, counter and shift register updates
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sout_q  <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic; line level and ready are derived from the next state
    // so both outputs change on the same edge as the state they belong to
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (accept_c) begin
                    shift_d = load_c;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        // Shifting once more leaves the parity bit at the output tap
                        shift_d = shift_q >> 1;
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif

            ST_STOP: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered line level and ready flag for the state being entered
    always_comb begin
        sout_d  = 1'b1;
        ready_d = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
                sout_d  = 1'b1;
                ready_d = 1'b1;
            end
            ST_START:  sout_d = 1'b0;
            ST_DATA:   sout_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: sout_d = shift_d[0];
`endif
            ST_STOP:   sout_d = 1'b1;
            default: begin
                sout_d  = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    assign SOut        = sout_q;
    assign DataInReady = ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLOCK_FREQ=1000, BAUD_RATE=100,
// which gives 10 cycles per symbol. The line is checked on every cycle of each frame.
module tb_uart_tx_serializer;

    localparam int SYM = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * SYM;
`else
    localparam int FRAME = 10 * SYM;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout;

    int checks;
    int failures;

    uart_tx_serializer #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
        .DataIn      (din),
        .DataInValid (din_valid),
        .DataInReady (din_ready),
        .SOut        (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference line level for cycle k (1-based) after the accept edge
    function automatic logic exp_sout(input logic [7:0] b, input int k);
        if (k <= SYM) return 1'b0;
        if (k <= 9 * SYM) return b[3'((k - SYM - 1) / SYM)];
`ifdef UART_TX_PARITY_EN
        if (k <= 10 * SYM) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present a byte after a negedge; it is accepted on the following posedge
    task automatic start_frame(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        chk($sformatf("ready_before_accept_%02h", b), din_ready, 1'b1);
        @(posedge clk);
    endtask

    // Check frame cycles lo..hi; cycle FRAME+1 is the idle cycle with ready back up
    task automatic run_cycles(input logic [7:0] b, input int lo, input int hi, input bit hold);
        for (int k = lo; k <= hi; k++) begin
            @(negedge clk);
            chk($sformatf("sout_%02h_c%0d", b, k), sout, exp_sout(b, k));
            chk($sformatf("ready_%02h_c%0d", b, k), din_ready, (k > FRAME));
            if (!hold) din_valid = 1'b0;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        din       = 8'hA5;
        din_valid = 1'b1;

        // 1: reset held with Valid high, nothing is accepted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_sout_%0d", i), sout, 1'b1);
            chk($sformatf("rst_ready_%0d", i), din_ready, 1'b1);
        end
        rst       = 1'b0;
        din_valid = 1'b0;

        // 6: idle line with no Valid
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            chk($sformatf("idle_sout_%0d", i), sout, 1'b1);
            chk($sformatf("idle_ready_%0d", i), din_ready, 1'b1);
        end

        // 2: single byte 0xA5
        start_frame(8'hA5);
        run_cycles(8'hA5, 1, FRAME + 1, 1'b0);

        // 3: Valid held, 0x00 then 0xFF with exactly one idle cycle between frames
        start_frame(8'h00);
        run_cycles(8'h00, 1, FRAME + 1, 1'b1);
        start_frame(8'hFF);
        run_cycles(8'hFF, 1, FRAME + 1, 1'b0);

        // 4: DataIn changed mid-frame does not disturb the frame
        start_frame(8'h81);
        run_cycles(8'h81, 1, 29, 1'b0);
        din = 8'h3C;
        run_cycles(8'h81, 30, FRAME + 1, 1'b0);

        // 5: reset mid-frame aborts, next byte goes out intact
        start_frame(8'hC3);
        run_cycles(8'hC3, 1, 45, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_sout", sout, 1'b1);
        chk("abort_ready", din_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_sout", sout, 1'b1);
        chk("post_abort_ready", din_ready, 1'b1);
        start_frame(8'h55);
        run_cycles(8'h55, 1, FRAME + 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
